// File: rtl/if_cic_decimator.sv
// ---------------------------------------------------------------------------
// if_cic_decimator
//
// Purpose:
//   Digital IF back-end stage that sits directly after the active mixer.
//   It takes ADC samples of the mixer's differential output (pos - neg) and
//   applies a 2nd-order CIC low-pass filter with decimation by
//   DECIM = 2**LOG2_DECIM. The filter removes the LO-rate products and
//   passes the baseband difference tone at the reduced rate.
//
//   The result goes out on a valid/ready stream with a one-entry holding
//   register. If a new result arrives while the previous one is still
//   waiting, the new result is dropped and the sticky overrun flag is set.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   in_data      signed sample (pos - neg), IN_W bits
//   in_valid     sample qualifier; samples are always accepted
//   out_data     signed decimated result, OUT_W bits
//   out_valid    result available
//   out_ready    consumer accepts out_data
//   overrun      sticky flag, a result was dropped
//   clr_overrun  synchronous clear of overrun (a coincident set wins)
// ---------------------------------------------------------------------------
module if_cic_decimator #(
    parameter int IN_W       = 12,
    parameter int LOG2_DECIM = 4,
    parameter int OUT_W      = IN_W + 2 * LOG2_DECIM
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [IN_W-1:0]  in_data,
    input  logic                    in_valid,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    overrun,
    input  logic                    clr_overrun
);

    // The last sample of a window arrives when the counter is all ones.
    localparam logic [LOG2_DECIM-1:0] CNT_LAST = '1;

    logic signed [OUT_W-1:0] i1_q, i1_d;
    logic signed [OUT_W-1:0] i2_q, i2_d;
    logic signed [OUT_W-1:0] d1_q, d1_d;
    logic signed [OUT_W-1:0] d2_q, d2_d;
    logic [LOG2_DECIM-1:0]   cnt_q, cnt_d;
    logic                    dump_q, dump_d;
    logic signed [OUT_W-1:0] out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic                    overrun_q, overrun_d;

    logic signed [OUT_W-1:0] in_ext;
    logic signed [OUT_W-1:0] i1_sum;
    logic signed [OUT_W-1:0] i2_sum;
    logic signed [OUT_W-1:0] c1;
    logic signed [OUT_W-1:0] c2;

    // Integrator and decimation counter next-state logic.
    // The integrators run at full OUT_W width and wrap modulo 2**OUT_W.
    // The comb section cancels the wrap, provided the true output fits in
    // OUT_W bits, so no saturation is applied here. The second integrator
    // adds the *updated* first-integrator value, so both stages advance on
    // the same sample. When there is no valid sample, everything holds.
    always_comb begin
        in_ext = {{(OUT_W - IN_W){in_data[IN_W-1]}}, in_data};
        i1_sum = i1_q + in_ext;
        i2_sum = i2_q + i1_sum;

        i1_d   = i1_q;
        i2_d   = i2_q;
        cnt_d  = cnt_q;
        dump_d = 1'b0;

        if (in_valid) begin
            i1_d   = i1_sum;
            i2_d   = i2_sum;
            cnt_d  = cnt_q + LOG2_DECIM'(1);
            dump_d = (cnt_q == CNT_LAST);
        end
    end

    // Comb section and output holding register.
    // dump_q is high for the single cycle after the last sample of a window.
    // At that point i2_q holds the integrated value for the whole window.
    // The comb delays always take their new values, even when the candidate
    // has to be dropped, so that the next result is still correct.
    // A stalled result is never overwritten. The new candidate is dropped
    // instead and the drop is recorded in overrun. A drop in the same cycle
    // as clr_overrun leaves the flag set.
    always_comb begin
        c1 = i2_q - d1_q;
        c2 = c1 - d2_q;

        d1_d        = d1_q;
        d2_d        = d2_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;

        if (clr_overrun) begin
            overrun_d = 1'b0;
        end

        if (dump_q) begin
            d1_d = i2_q;
            d2_d = c1;
            if (!out_valid_q || out_ready) begin
                out_data_d  = c2;
                out_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers. Reset takes priority over everything else and
    // discards any partial window.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            i1_q        <= '0;
            i2_q        <= '0;
            d1_q        <= '0;
            d2_q        <= '0;
            cnt_q       <= '0;
            dump_q      <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            i1_q        <= i1_d;
            i2_q        <= i2_d;
            d1_q        <= d1_d;
            d2_q        <= d2_d;
            cnt_q       <= cnt_d;
            dump_q      <= dump_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_if_cic_decimator.sv
// ---------------------------------------------------------------------------
// tb_if_cic_decimator
//
// Self-checking bench for if_cic_decimator. Every accepted sample since the
// last reset is kept in a queue. Each expected output is the convolution of
// that history with the triangular CIC impulse response (taps 1..D..1) and
// is then reduced modulo 2**OUT_W.
// ---------------------------------------------------------------------------
module tb_if_cic_decimator;

    localparam int IN_W       = 12;
    localparam int LOG2_DECIM = 4;
    localparam int DECIM      = 1 << LOG2_DECIM;
    localparam int OUT_W      = IN_W + 2 * LOG2_DECIM;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic signed [IN_W-1:0]  in_data = '0;
    logic                    in_valid = 1'b0;
    logic signed [OUT_W-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready = 1'b1;
    logic                    overrun;
    logic                    clr_overrun = 1'b0;

    int vectors     = 0;
    int miscompares = 0;
    int hist[$];
    int nout      = 0;
    int edge_cnt  = 0;
    int win_edge  = -100;
    int prev_edge = 0;

    if_cic_decimator #(
        .IN_W       (IN_W),
        .LOG2_DECIM (LOG2_DECIM),
        .OUT_W      (OUT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    always #5 clk = ~clk;

    // Reference: output n (1-based) is the sum of h[k] * x[nD-1-k] over
    // the 2D-1 taps of the triangular impulse response.
    function automatic logic signed [OUT_W-1:0] model_out(input int n);
        longint acc = 0;
        longint h;
        int     idx;
        for (int k = 0; k < 2 * DECIM - 1; k++) begin
            idx = n * DECIM - 1 - k;
            h   = (k < DECIM) ? longint'(k + 1) : longint'(2 * DECIM - 1 - k);
            if (idx >= 0 && idx < hist.size()) acc += h * longint'(hist[idx]);
        end
        return acc[OUT_W-1:0];
    endfunction

    // Drive one clock cycle. Samples accepted by the DUT are logged, along
    // with the edge on which each window completes. Returns 1 ns after the
    // edge so outputs can be sampled safely.
    task automatic step(input bit v, input int d);
        in_valid = v;
        in_data  = IN_W'(d);
        @(posedge clk);
        edge_cnt++;
        if (v && rst_n) begin
            hist.push_back(d);
            if (hist.size() % DECIM == 0) win_edge = edge_cnt;
        end
        #1;
    endtask

    task automatic do_reset(input bit v);
        rst_n       = 1'b0;
        clr_overrun = 1'b0;
        step(v, 100);
        rst_n = 1'b1;
        hist.delete();
        nout     = 0;
        win_edge = -100;
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        do_reset(1'b0);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        vectors++;
        if (overrun !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_overrun: got %b expected 0", overrun);
        end
        vectors++;
        if (out_data !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_out_data: got %0d expected 0", out_data);
        end
    endtask

    task automatic test_dc_step();
        logic signed [OUT_W-1:0] expv;
        do_reset(1'b0);
        out_ready = 1'b1;
        for (int s = 0; s < 5 * DECIM + 3; s++) begin
            step(1'b1, 100);
            if (out_valid === 1'b1) begin
                nout++;
                expv = (nout == 1) ? OUT_W'(13600) : OUT_W'(25600);
                vectors++;
                if (out_data !== expv) begin
                    miscompares++;
                    $display("[TB] FAIL dc_value #%0d: got %0d expected %0d", nout, out_data, expv);
                end
                vectors++;
                if (out_data !== model_out(nout)) begin
                    miscompares++;
                    $display("[TB] FAIL dc_model #%0d: got %0d expected %0d", nout, out_data, model_out(nout));
                end
                vectors++;
                if (edge_cnt != win_edge + 1) begin
                    miscompares++;
                    $display("[TB] FAIL dc_latency #%0d: got edge %0d expected %0d", nout, edge_cnt, win_edge + 1);
                end
            end
        end
        vectors++;
        if (nout != 5) begin
            miscompares++;
            $display("[TB] FAIL dc_count: got %0d outputs expected 5", nout);
        end
    endtask

    task automatic test_lo_rejection();
        logic signed [OUT_W-1:0] expv;
        do_reset(1'b0);
        out_ready = 1'b1;
        for (int s = 0; s < 4 * DECIM + 2; s++) begin
            step(1'b1, (s % 2 == 0) ? 1000 : -1000);
            if (out_valid === 1'b1) begin
                nout++;
                expv = (nout == 1) ? OUT_W'(8000) : OUT_W'(0);
                vectors++;
                if (out_data !== expv || out_data !== model_out(nout)) begin
                    miscompares++;
                    $display("[TB] FAIL lo_value #%0d: got %0d expected %0d", nout, out_data, expv);
                end
            end
        end
        vectors++;
        if (nout != 4) begin
            miscompares++;
            $display("[TB] FAIL lo_count: got %0d outputs expected 4", nout);
        end
    endtask

    task automatic test_full_scale();
        logic signed [OUT_W-1:0] last_out;
        logic signed [OUT_W-1:0] expv;
        int                      bad;
        do_reset(1'b0);
        out_ready = 1'b1;
        last_out  = '0;
        for (int ph = 0; ph < 2; ph++) begin
            bad = 0;
            for (int s = 0; s <= 10000; s++) begin
                if (s < 10000) step(1'b1, (ph == 0) ? 2047 : -2048);
                else           step(1'b0, 0);
                if (out_valid === 1'b1) begin
                    nout++;
                    last_out = out_data;
                    vectors++;
                    if (out_data !== model_out(nout)) begin
                        miscompares++;
                        if (bad < 4)
                            $display("[TB] FAIL fullscale_model #%0d: got %0d expected %0d", nout, out_data, model_out(nout));
                        bad++;
                    end
                end
            end
            expv = (ph == 0) ? OUT_W'(524032) : OUT_W'(-524288);
            vectors++;
            if (last_out !== expv) begin
                miscompares++;
                $display("[TB] FAIL fullscale_steady ph%0d: got %0d expected %0d", ph, last_out, expv);
            end
        end
    endtask

    task automatic test_backpressure();
        bit seen;
        int wins;
        do_reset(1'b0);
        out_ready = 1'b0;
        for (int s = 0; s < 40; s++) begin
            step(1'b1, 100);
            if (out_valid === 1'b1) begin
                vectors++;
                if (out_data !== OUT_W'(13600)) begin
                    miscompares++;
                    $display("[TB] FAIL bp_hold s%0d: got %0d expected 13600", s, out_data);
                end
            end
        end
        vectors++;
        if (out_valid !== 1'b1 || overrun !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL bp_stalled: got valid=%b overrun=%b expected 1/1", out_valid, overrun);
        end
        out_ready = 1'b1;
        step(1'b1, 100);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_release: got out_valid=%b expected 0", out_valid);
        end
        seen = 1'b0;
        for (int s = 0; s < 20 && !seen; s++) begin
            step(1'b1, 100);
            if (out_valid === 1'b1) begin
                seen = 1'b1;
                vectors++;
                if (out_data !== OUT_W'(25600)) begin
                    miscompares++;
                    $display("[TB] FAIL bp_next: got %0d expected 25600", out_data);
                end
            end
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("[TB] FAIL bp_next_timeout: got no out_valid expected one within 20 cycles");
        end
        step(1'b0, 0);
        vectors++;
        if (overrun !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL bp_sticky: got overrun=%b expected 1", overrun);
        end
        clr_overrun = 1'b1;
        step(1'b0, 0);
        clr_overrun = 1'b0;
        vectors++;
        if (overrun !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_clear: got overrun=%b expected 0", overrun);
        end
        out_ready = 1'b0;
        wins = 0;
        for (int s = 0; s < 3 * DECIM && wins < 2; s++) begin
            step(1'b1, 100);
            if (hist.size() % DECIM == 0) wins++;
        end
        clr_overrun = 1'b1;
        step(1'b1, 100);
        clr_overrun = 1'b0;
        vectors++;
        if (overrun !== 1'b1 || wins != 2) begin
            miscompares++;
            $display("[TB] FAIL bp_clr_vs_drop: got overrun=%b wins=%0d expected 1 and 2", overrun, wins);
        end
    endtask

    task automatic test_reset_mid_window();
        out_ready = 1'b0;
        for (int s = 0; s < 7; s++) step(1'b1, 100);
        do_reset(1'b1);
        vectors++;
        if (out_valid !== 1'b0 || overrun !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midreset_flags: got valid=%b overrun=%b expected 0/0", out_valid, overrun);
        end
        out_ready = 1'b1;
        for (int s = 0; s < DECIM + 2; s++) begin
            step(s < DECIM, 100);
            if (out_valid === 1'b1) begin
                nout++;
                vectors++;
                if (out_data !== OUT_W'(13600) || edge_cnt != win_edge + 1) begin
                    miscompares++;
                    $display("[TB] FAIL midreset_value: got %0d at edge %0d expected 13600 at %0d", out_data, edge_cnt, win_edge + 1);
                end
            end
        end
        vectors++;
        if (nout != 1) begin
            miscompares++;
            $display("[TB] FAIL midreset_count: got %0d outputs expected 1", nout);
        end
    endtask

    task automatic test_sparse();
        logic signed [OUT_W-1:0] expv;
        do_reset(1'b0);
        out_ready = 1'b1;
        for (int c = 0; c < 5 * DECIM * 3 + 6; c++) begin
            step(c % 3 == 0, 100);
            if (out_valid === 1'b1) begin
                nout++;
                expv = (nout == 1) ? OUT_W'(13600) : OUT_W'(25600);
                vectors++;
                if (out_data !== expv || out_data !== model_out(nout)) begin
                    miscompares++;
                    $display("[TB] FAIL sparse_value #%0d: got %0d expected %0d", nout, out_data, expv);
                end
                vectors++;
                if (edge_cnt != win_edge + 1 || (nout > 1 && edge_cnt - prev_edge != 3 * DECIM)) begin
                    miscompares++;
                    $display("[TB] FAIL sparse_timing #%0d: got edge %0d (prev %0d) expected %0d", nout, edge_cnt, prev_edge, win_edge + 1);
                end
                prev_edge = edge_cnt;
            end
        end
        vectors++;
        if (nout != 5) begin
            miscompares++;
            $display("[TB] FAIL sparse_count: got %0d outputs expected 5", nout);
        end
    endtask

    task automatic test_random();
        bit v;
        int d;
        do_reset(1'b0);
        out_ready = 1'b1;
        for (int c = 0; c < 402; c++) begin
            v = (c < 400) && ($urandom_range(0, 3) != 0);
            d = int'($urandom_range(0, 4095)) - 2048;
            step(v, d);
            if (out_valid === 1'b1) begin
                nout++;
                vectors++;
                if (out_data !== model_out(nout) || edge_cnt != win_edge + 1) begin
                    miscompares++;
                    $display("[TB] FAIL random #%0d: got %0d at edge %0d expected %0d at %0d", nout, out_data, edge_cnt, model_out(nout), win_edge + 1);
                end
            end
        end
        vectors++;
        if (nout != hist.size() / DECIM) begin
            miscompares++;
            $display("[TB] FAIL random_count: got %0d outputs expected %0d", nout, hist.size() / DECIM);
        end
    endtask

    initial begin
        $display("[TB] starting if_cic_decimator bench");
        test_reset();
        test_dc_step();
        test_lo_rejection();
        test_full_scale();
        test_backpressure();
        test_reset_mid_window();
        test_sparse();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
